// File: rtl/decodificador_johnson_pkg.sv
// Shared types and helpers for the Johnson counter phase decoder.
// Optional stall-as-error behaviour is selected with JOHNSON_PARADA_ERRO_EN
// (see decodificador_johnson.sv).
package pkg_johnson;

    // Lock-tracking FSM states.
    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        SINC    = 2'd1,
        TRAVADO = 2'd2
    } fsm_estado_t;

    // Error counter saturation value.
    localparam logic [7:0] ERROS_MAX = 8'hFF;

    // Number of ones in a code (codes narrower than 32 bits are zero-extended).
    function automatic int unsigned conta_uns(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/decodificador_johnson_if.sv
// Bus between the Johnson counter output and the decoder.
// Handshake: valido_in qualifies estado_in for exactly the cycle it is high;
// there is no backpressure. valido_out likewise qualifies fase_out/fase_oh for
// one cycle. estado_fsm exposes the lock FSM state for observation.
interface decodificador_johnson_if #(
    parameter int N = 6
);
    import pkg_johnson::*;

    localparam int FW = $clog2(2 * N);

    logic [N-1:0]   estado_in;
    logic           valido_in;
    logic [FW-1:0]  fase_out;
    logic [2*N-1:0] fase_oh;
    logic           valido_out;
    logic           erro_codigo;
    logic           erro_seq;
    logic [7:0]     cont_erros;
    logic           travado;
    fsm_estado_t    estado_fsm;

    // Sampling side (counter / testbench).
    modport master (
        output estado_in, valido_in,
        input  fase_out, fase_oh, valido_out, erro_codigo, erro_seq,
               cont_erros, travado, estado_fsm
    );

    // Decoder side.
    modport slave (
        input  estado_in, valido_in,
        output fase_out, fase_oh, valido_out, erro_codigo, erro_seq,
               cont_erros, travado, estado_fsm
    );

endinterface

// File: rtl/decodificador_johnson_fase_comb.sv
// Purely combinational map from a Johnson counter word to {legal, phase}.
// A word is legal when at most one adjacent bit pair differs; the phase is
// derived from the number of ones and the value of bit 0.
module johnson_fase_comb
    import pkg_johnson::*;
#(
    parameter int N  = 6,
    parameter int FW = $clog2(2 * N)
) (
    input  logic [N-1:0]  estado,
    output logic          legal,
    output logic [FW-1:0] fase
);

    int unsigned transicoes;
    int unsigned uns;

    // Count adjacent transitions and ones, then derive legality and phase.
    always_comb begin
        transicoes = 0;
        for (int i = 0; i < N - 1; i++) begin
            transicoes = transicoes + {31'd0, estado[i] ^ estado[i+1]};
        end
        uns   = conta_uns(32'(estado));
        legal = (transicoes <= 1);
        if (uns == 0) begin
            fase = '0;
        end else if (estado[0]) begin
            fase = FW'(uns);
        end else begin
            fase = FW'(32'(2 * N) - uns);
        end
    end

endmodule

// File: rtl/decodificador_johnson.sv
// Johnson counter phase decoder: decodes sampled counter words to a phase
// index and one-hot vector, flags illegal codes and out-of-sequence phases,
// and tracks lock through a BUSCA/SINC/TRAVADO FSM.
// Build option JOHNSON_PARADA_ERRO_EN: when defined, a repeated phase (stall)
// is reported as a sequence error instead of being accepted silently.
module decodificador_johnson
    import pkg_johnson::*;
#(
    parameter int N         = 6,
    parameter int TRAVA_CNT = 3
) (
    input logic                    clk,
    input logic                    reset,
    decodificador_johnson_if.slave bus
);

    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FASE_ULTIMA = FW'(2 * N - 1);
    localparam logic [3:0]    TRAVA_ALVO  = 4'(TRAVA_CNT);
`ifdef JOHNSON_PARADA_ERRO_EN
    localparam bit PARADA_ERRO = 1'b1;
`else
    localparam bit PARADA_ERRO = 1'b0;
`endif

    logic           legal;
    logic [FW-1:0]  fase;

    logic [FW-1:0]  fase_q;
    logic [2*N-1:0] oh_q;
    logic           valido_q;
    logic           erro_cod_q;
    logic           erro_seq_q;
    logic [7:0]     cont_q;
    fsm_estado_t    estado_q;
    logic           ref_valido_q;
    logic [FW-1:0]  ref_fase_q;
    logic [3:0]     avancos_q;

    logic [FW-1:0]  fase_prox;
    logic           eh_avanco;
    logic           eh_parada;
    logic           seq_err;
    logic           erro_any;
    logic [7:0]     cont_inc;
    logic [3:0]     avancos_inc;
    logic [2*N-1:0] oh_d;

    johnson_fase_comb #(.N(N), .FW(FW)) u_fase (
        .estado (bus.estado_in),
        .legal  (legal),
        .fase   (fase)
    );

    // Classify the incoming sample against the reference phase.
    always_comb begin
        fase_prox   = (ref_fase_q == FASE_ULTIMA) ? '0 : ref_fase_q + FW'(1);
        eh_avanco   = ref_valido_q && (fase == fase_prox);
        eh_parada   = ref_valido_q && (fase == ref_fase_q);
        seq_err     = (ref_valido_q && !eh_avanco && !eh_parada) ||
                      (eh_parada && PARADA_ERRO);
        erro_any    = bus.valido_in && (!legal || seq_err);
        cont_inc    = (cont_q == ERROS_MAX) ? cont_q : cont_q + 8'd1;
        avancos_inc = (avancos_q == 4'hF) ? avancos_q : avancos_q + 4'd1;
        oh_d        = {{(2*N-1){1'b0}}, 1'b1} << fase;
    end

    // Lock FSM, reference phase and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fase_q       <= '0;
            oh_q         <= '0;
            valido_q     <= 1'b0;
            erro_cod_q   <= 1'b0;
            erro_seq_q   <= 1'b0;
            cont_q       <= '0;
            estado_q     <= BUSCA;
            ref_valido_q <= 1'b0;
            ref_fase_q   <= '0;
            avancos_q    <= '0;
        end else begin
            valido_q   <= 1'b0;
            erro_cod_q <= 1'b0;
            erro_seq_q <= 1'b0;
            oh_q       <= '0;
            if (bus.valido_in) begin
                if (!legal) begin
                    erro_cod_q   <= 1'b1;
                    ref_valido_q <= 1'b0;
                    avancos_q    <= '0;
                    estado_q     <= BUSCA;
                end else begin
                    valido_q     <= 1'b1;
                    fase_q       <= fase;
                    oh_q         <= oh_d;
                    ref_fase_q   <= fase;
                    ref_valido_q <= 1'b1;
                    if (!ref_valido_q) begin
                        avancos_q <= '0;
                        estado_q  <= SINC;
                    end else if (eh_avanco) begin
                        avancos_q <= avancos_inc;
                        if (estado_q == SINC && avancos_inc >= TRAVA_ALVO) begin
                            estado_q <= TRAVADO;
                        end
                    end else if (seq_err) begin
                        erro_seq_q <= 1'b1;
                        avancos_q  <= '0;
                        estado_q   <= SINC;
                    end
                end
                if (erro_any) begin
                    cont_q <= cont_inc;
                end
            end
        end
    end

    assign bus.fase_out    = fase_q;
    assign bus.fase_oh     = oh_q;
    assign bus.valido_out  = valido_q;
    assign bus.erro_codigo = erro_cod_q;
    assign bus.erro_seq    = erro_seq_q;
    assign bus.cont_erros  = cont_q;
    assign bus.travado     = (estado_q == TRAVADO);
    assign bus.estado_fsm  = estado_q;

endmodule

// File: tb/tb_decodificador_johnson.sv
// Self-checking bench for decodificador_johnson (N=6, TRAVA_CNT=3).
// Honours JOHNSON_PARADA_ERRO_EN for the stall expectations.
module tb_decodificador_johnson;
    import pkg_johnson::*;

    localparam int N  = 6;
    localparam int FW = 4;
    localparam int TRAVA = 3;
    localparam int W  = FW + 2*N + 1 + 1 + 1 + 8 + 1;
`ifdef JOHNSON_PARADA_ERRO_EN
    localparam bit PARADA = 1'b1;
`else
    localparam bit PARADA = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decodificador_johnson_if #(.N(N)) bus ();

    decodificador_johnson #(.N(N), .TRAVA_CNT(TRAVA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Stand-alone decoder instance, checked against the counter table.
    logic [N-1:0]  c_estado;
    logic          c_legal;
    logic [FW-1:0] c_fase;
    johnson_fase_comb #(.N(N), .FW(FW)) u_ref (
        .estado (c_estado),
        .legal  (c_legal),
        .fase   (c_fase)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int code2ph[64];
    int ph2code[12];
    bit m_rv;
    int m_ref, m_cnt, m_state, m_fase, m_errs;

    logic [W-1:0] exp_q[$];

    task automatic build_tables();
        int c;
        for (int i = 0; i < 64; i++) code2ph[i] = -1;
        c = 0;
        for (int k = 0; k < 2*N; k++) begin
            code2ph[c] = k;
            ph2code[k] = c;
            c = ((c << 1) & 63) | (((c >> 5) & 1) ^ 1);
        end
    endtask

    task automatic modelo(input logic rst, input logic vld, input logic [N-1:0] code);
        bit vo, ec, es;
        logic [2*N-1:0] oh;
        int ph;
        vo = 0; ec = 0; es = 0; oh = '0;
        if (rst) begin
            m_rv = 0; m_ref = 0; m_cnt = 0; m_state = 0; m_fase = 0; m_errs = 0;
        end else if (vld) begin
            ph = code2ph[code];
            if (ph < 0) begin
                ec = 1; m_rv = 0; m_cnt = 0; m_state = 0;
            end else begin
                vo = 1; m_fase = ph; oh = 12'(1) << ph;
                if (!m_rv) begin
                    m_rv = 1; m_state = 1; m_cnt = 0;
                end else if (ph == (m_ref + 1) % (2*N)) begin
                    if (m_cnt < 15) m_cnt++;
                    if (m_state == 1 && m_cnt >= TRAVA) m_state = 2;
                end else if (ph == m_ref) begin
                    if (PARADA) begin
                        es = 1; m_cnt = 0; m_state = 1;
                    end
                end else begin
                    es = 1; m_cnt = 0; m_state = 1;
                end
                m_ref = ph;
            end
            if ((ec || es) && m_errs < 255) m_errs++;
        end
        exp_q.push_back({4'(m_fase), oh, vo, ec, es, 8'(m_errs), (m_state == 2)});
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; applies one cycle of stimulus.
    task automatic ciclo(input logic rst, input logic vld, input logic [N-1:0] code);
        reset = rst;
        bus.valido_in = vld;
        bus.estado_in = code;
        modelo(rst, vld, code);
        @(negedge clk);
    endtask

    task automatic amostra(input int ph);
        ciclo(1'b0, 1'b1, 6'(ph2code[ph]));
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] sb_exp, sb_act;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {bus.fase_out, bus.fase_oh, bus.valido_out, bus.erro_codigo,
                      bus.erro_seq, bus.cont_erros, bus.travado};
            n_tests++;
            if (sb_act !== sb_exp) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got %h exp %h", $time, sb_act, sb_exp);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_comb();
        for (int code = 0; code < 64; code++) begin
            c_estado = 6'(code);
            #1;
            n_tests++;
            if (c_legal !== (code2ph[code] >= 0) ||
                (c_legal && c_fase !== 4'(code2ph[code]))) begin
                n_fail++;
                $display("FAIL comb code=%b got legal=%0b fase=%0d exp phase %0d",
                         6'(code), c_legal, c_fase, code2ph[code]);
            end
        end
    endtask

    task automatic test_reset();
        ciclo(1'b1, 1'b1, 6'b000111);
        ciclo(1'b1, 1'b0, 6'b000000);
        n_tests++;
        if (bus.valido_out !== 1'b0 || bus.travado !== 1'b0 || bus.cont_erros !== 8'd0 ||
            bus.fase_oh !== 12'd0 || bus.estado_fsm !== BUSCA) begin
            n_fail++;
            $display("FAIL reset got vo=%b trav=%b cont=%0d oh=%h fsm=%0d exp all zero/BUSCA",
                     bus.valido_out, bus.travado, bus.cont_erros, bus.fase_oh, bus.estado_fsm);
        end
    endtask

    task automatic test_sequencia();
        logic [5:0] codes[4];
        codes = '{6'b000000, 6'b000001, 6'b000011, 6'b000111};
        for (int i = 0; i < 4; i++) begin
            ciclo(1'b0, 1'b1, codes[i]);
            n_tests++;
            if (bus.fase_out !== 4'(i) || bus.fase_oh !== (12'd1 << i) ||
                bus.erro_seq !== 1'b0 || bus.erro_codigo !== 1'b0) begin
                n_fail++;
                $display("FAIL seq[%0d] got fase=%0d oh=%h es=%b ec=%b exp fase=%0d",
                         i, bus.fase_out, bus.fase_oh, bus.erro_seq, bus.erro_codigo, i);
            end
        end
        n_tests++;
        if (bus.travado !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_trava got %b exp 1", bus.travado);
        end
    endtask

    task automatic test_wrap();
        for (int k = 4; k < 4 + 2*N + 8 + 1; k++) begin
            amostra(k % (2*N));
            n_tests++;
            if (bus.erro_seq !== 1'b0 || bus.travado !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap[%0d] got es=%b trav=%b exp es=0 trav=1",
                         k % (2*N), bus.erro_seq, bus.travado);
            end
        end
        n_tests++;
        if (bus.fase_out !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_fase got %0d exp 0", bus.fase_out);
        end
    endtask

    task automatic test_ilegal();
        ciclo(1'b0, 1'b1, 6'b010100);
        n_tests++;
        if (bus.erro_codigo !== 1'b1 || bus.valido_out !== 1'b0 || bus.travado !== 1'b0 ||
            bus.cont_erros !== 8'd1 || bus.fase_oh !== 12'd0 || bus.fase_out !== 4'd0) begin
            n_fail++;
            $display("FAIL ilegal got ec=%b vo=%b trav=%b cont=%0d oh=%h fase=%0d exp 1,0,0,1,0,0",
                     bus.erro_codigo, bus.valido_out, bus.travado, bus.cont_erros,
                     bus.fase_oh, bus.fase_out);
        end
        amostra(1);
        n_tests++;
        if (bus.erro_seq !== 1'b0 || bus.erro_codigo !== 1'b0 || bus.valido_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ilegal_seguinte got es=%b ec=%b vo=%b exp 0,0,1",
                     bus.erro_seq, bus.erro_codigo, bus.valido_out);
        end
        amostra(2); amostra(3); amostra(4);
        n_tests++;
        if (bus.travado !== 1'b1) begin
            n_fail++;
            $display("FAIL ilegal_retrava got %b exp 1", bus.travado);
        end
    endtask

    task automatic test_salto();
        ciclo(1'b1, 1'b0, 6'b000000);
        for (int k = 0; k < 4; k++) amostra(k);
        ciclo(1'b0, 1'b1, 6'b111100);
        n_tests++;
        if (bus.erro_seq !== 1'b1 || bus.travado !== 1'b0 || bus.cont_erros !== 8'd1 ||
            bus.fase_out !== 4'd8) begin
            n_fail++;
            $display("FAIL salto got es=%b trav=%b cont=%0d fase=%0d exp 1,0,1,8",
                     bus.erro_seq, bus.travado, bus.cont_erros, bus.fase_out);
        end
        amostra(9); amostra(10);
        n_tests++;
        if (bus.travado !== 1'b0) begin
            n_fail++;
            $display("FAIL salto_cedo got %b exp 0", bus.travado);
        end
        amostra(11);
        n_tests++;
        if (bus.travado !== 1'b1) begin
            n_fail++;
            $display("FAIL salto_retrava got %b exp 1", bus.travado);
        end
    endtask

    task automatic test_parada();
        ciclo(1'b1, 1'b0, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            ciclo(1'b0, 1'b1, 6'b000011);
            n_tests++;
            if (bus.erro_seq !== ((i > 0) && PARADA) || bus.fase_out !== 4'd2) begin
                n_fail++;
                $display("FAIL parada[%0d] got es=%b fase=%0d exp es=%b fase=2",
                         i, bus.erro_seq, bus.fase_out, (i > 0) && PARADA);
            end
        end
        n_tests++;
        if (bus.cont_erros !== (PARADA ? 8'd2 : 8'd0)) begin
            n_fail++;
            $display("FAIL parada_cont got %0d exp %0d", bus.cont_erros, PARADA ? 2 : 0);
        end
    endtask

    task automatic test_saturacao();
        logic [5:0] code;
        ciclo(1'b1, 1'b0, 6'b000000);
        for (int i = 0; i < 300; i++) begin
            do code = 6'($urandom_range(0, 63)); while (code2ph[code] >= 0);
            ciclo(1'b0, 1'b1, code);
        end
        n_tests++;
        if (bus.cont_erros !== 8'd255) begin
            n_fail++;
            $display("FAIL saturacao got %0d exp 255", bus.cont_erros);
        end
        amostra(5); amostra(6);
        ciclo(1'b1, 1'b1, 6'b011111);
        n_tests++;
        if ({bus.fase_out, bus.fase_oh, bus.valido_out, bus.erro_codigo, bus.erro_seq,
             bus.cont_erros, bus.travado} !== '0) begin
            n_fail++;
            $display("FAIL reset_meio got fase=%0d oh=%h vo=%b cont=%0d exp all zero",
                     bus.fase_out, bus.fase_oh, bus.valido_out, bus.cont_erros);
        end
        amostra(9);
        n_tests++;
        if (bus.erro_seq !== 1'b0 || bus.valido_out !== 1'b1 || bus.fase_out !== 4'd9) begin
            n_fail++;
            $display("FAIL pos_reset got es=%b vo=%b fase=%0d exp 0,1,9",
                     bus.erro_seq, bus.valido_out, bus.fase_out);
        end
    endtask

    task automatic test_aleatorio();
        int r;
        logic [5:0] code;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                ciclo(1'b0, 1'b0, 6'($urandom_range(0, 63)));
            end else if (r == 1) begin
                do code = 6'($urandom_range(0, 63)); while (code2ph[code] >= 0);
                ciclo(1'b0, 1'b1, code);
            end else if (r == 2 && m_rv) begin
                amostra(m_ref);
            end else if (r == 3 || !m_rv) begin
                amostra($urandom_range(0, 2*N - 1));
            end else begin
                amostra((m_ref + 1) % (2*N));
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        bus.valido_in = 1'b0;
        bus.estado_in = '0;
        build_tables();
        test_comb();
        @(negedge clk);
        test_reset();
        test_sequencia();
        test_wrap();
        test_ilegal();
        test_salto();
        test_parada();
        test_saturacao();
        test_aleatorio();
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decodificador_johnson.md
Name: decodificador_johnson

Overview:
- Receive-side companion of the N-bit twisted-ring (Johnson) counter. Samples the counter's parallel state word.
- Decodes each sample to a phase index 0..2N-1 and a one-hot phase vector.
- Flags codes that are not legal Johnson codes and samples that do not follow the counter sequence.
- Tracks lock to the counter through a small FSM. Sits directly on the counter's output bus, in the counter's clock domain.

Parameters:
- N, 6, counter width; the block decodes 2N legal phases.
- TRAVA_CNT, 3, number of consecutive correct advances needed to enter TRAVADO (range 1..15).
- FW, $clog2(2*N), phase index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- estado_in  input  N  sampled counter state; bit 0 is the stage fed by the inverted last stage.
- valido_in  input  1  estado_in is sampled on this cycle.
- fase_out  output  FW  decoded phase index.
- fase_oh  output  2N  one-hot phase: bit fase_out is set when valido_out=1, all zeros otherwise.
- valido_out  output  1  fase_out and fase_oh are valid.
- erro_codigo  output  1  one-cycle pulse: an illegal code was sampled.
- erro_seq  output  1  one-cycle pulse: a legal code arrived out of sequence.
- cont_erros  output  8  saturating count of all error pulses.
- travado  output  1  FSM is in TRAVADO.

Behaviour:
- Reset: already decided, one clock; reset is synchronous and active-high. When reset is high at a clk edge, every output goes to 0 and the FSM goes to BUSCA. The reference phase is cleared. Reset takes priority over valido_in.
- Latency: all outputs are registered. A sample taken at edge k appears on the outputs after edge k.
- valido_in=0: valido_out=0, error pulses=0. fase_out, cont_erros and the FSM hold their values.
- Legality rule: count the positions i in 0..N-2 where bit i differs from bit i+1. A code is legal iff that count is at most 1. For N=6 this gives 12 legal codes out of 64.
- Phase mapping, with w = number of ones in the code:
  - all zeros gives phase 0;
  - bit0=1 gives phase w (1..N);
  - bit0=0 with w>0 gives phase 2N-w.
  - Example for N=6: 000011 is phase 2, 111110 is phase 7, 100000 is phase 11.
- Illegal sample:
  - erro_codigo=1, valido_out=0, fase_out holds its value, fase_oh is all zeros;
  - the reference phase is invalidated and the FSM goes to BUSCA.
- Legal sample with no reference phase: no error. Outputs are updated, the reference is set to this phase, and the FSM goes to SINC with the good-advance count at 0.
- Legal sample with a reference phase p:
  - phase (p+1) mod 2N is a good advance: count+1;
  - phase p is a stall: no error, count unchanged (default build);
  - any other phase sets erro_seq=1, resets count to 0, sets the reference to the new phase, and moves TRAVADO or SINC to SINC.
- Wrap: a sample at phase 2N-1 (100000 for N=6) followed by phase 0 (000000) is a good advance.
- FSM states BUSCA, SINC, TRAVADO:
  - SINC goes to TRAVADO when the count reaches TRAVA_CNT;
  - TRAVADO stays as long as samples are good or stalls;
  - any error leaves TRAVADO. travado=1 only in TRAVADO.
- cont_erros: increments by 1 for each erro_codigo or erro_seq pulse, saturates at 255, and clears only on reset.
- Reset mid-stream: the next sample after reset is treated as having no reference phase, so it cannot raise erro_seq.

Optional Feature:
- Macro: JOHNSON_PARADA_ERRO_EN.
- Defined: a legal sample equal to the reference phase is a sequence error. erro_seq=1, the count resets to 0, the FSM leaves TRAVADO for SINC, and cont_erros increments.
- Undefined: a stall is accepted silently, as described in Behaviour.

Decomposition:
- Package pkg_johnson holds:
  - the FSM state enum (BUSCA, SINC, TRAVADO);
  - the saturation constant 8'hFF;
  - the function for the number of ones in a code.
- One sub-module: johnson_fase_comb. It is purely combinational and maps estado_in to {legal, phase}. It is reused by the decoder and by the bench's reference model.

Test Plan:
- Reset is held for 2 cycles, then a good counter sequence 000000,000001,000011,000111 is applied with valido_in=1 -> outputs read fase_out 0,1,2,3, fase_oh 0x001,0x002,0x004,0x008, travado=1 after the 4th sample (TRAVA_CNT=3), no errors.
- Full cycle of 12 codes followed by 100000 then 000000 -> the wrap is accepted, erro_seq stays 0, and travado remains 1.
- Illegal code 010100 injected while locked -> erro_codigo=1 for one cycle, valido_out=0, travado=0, cont_erros=1. The next legal code raises no erro_seq.
- Phase jump from 000111 (phase 3) to 111100 (phase 8) while locked -> erro_seq=1, travado drops, cont_erros increments, and relock follows 3 good advances.
- Repeated 000011 for 3 samples -> no error by default. With JOHNSON_PARADA_ERRO_EN defined -> erro_seq=1 on the 2nd and 3rd samples.
- 300 consecutive illegal samples -> cont_erros saturates at 255. Reset asserted mid-stream -> all outputs are 0 on the next edge.
